// File: rtl/interboard_pkg.sv
// Shared definitions for the inter-board link (receiver and transmitter):
// message-type codes, beat tag position and the receiver FSM state type.
package interboard_pkg;

  localparam logic [2:0] MSG_RESET  = 3'd0;
  localparam logic [2:0] MSG_START  = 3'd1;
  localparam logic [2:0] MSG_NUMBER = 3'd2;
  localparam logic [2:0] MSG_WIN    = 3'd3;
  localparam logic [2:0] MSG_ACK    = 3'd4;

  // Beat bit 5 distinguishes beat 0 (type) from beat 1 (number)
  localparam int unsigned TAG_BIT = 5;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    ACK_B0  = 2'd1,
    WAIT_B1 = 2'd2,
    ACK_B1  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_bit.sv
// Single-bit flop-chain synchroniser, STAGES deep, resetting to 0.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= '0;
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/inter_link_rx.sv
// Receive side of the inter-board link: four-phase Request_in/Ack_out
// handshake, two 6-bit beats per message, one-cycle interboard_en pulse
// per complete message. Optional mid-message watchdog: INTER_RX_TIMEOUT_EN.
module inter_link_rx
  import interboard_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Request_in,
  input  logic [5:0] inter_data_in,
  output logic       Ack_out,
  output logic       interboard_en,
  output logic [2:0] interboard_msg_type,
  output logic [4:0] interboard_number,
  output logic       interboard_rst,
  output logic       frame_err
);

  rx_state_t  state;
  logic       req_s;
  logic       primed;
  logic       armed;
  logic       discard;
  logic [2:0] type_q;
  logic [4:0] num_q;

  sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (Request_in),
    .q   (req_s)
  );

  // The request chain resets to 0, so its output is meaningless until it has
  // been refilled; a matching chain fed with 1 marks when req_s is real, which
  // keeps a request held high through reset release from arming the receiver.
  sync_bit #(.STAGES(SYNC_STAGES)) u_prime (
    .clk (clk),
    .rst (rst),
    .d   (1'b1),
    .q   (primed)
  );

`ifdef INTER_RX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             leave;
  logic             tmo_hit;

  // State-change condition of the FSM; the watchdog restarts on any change
  always_comb begin
    leave = 1'b0;
    case (state)
      WAIT_B0:        leave = armed && req_s;
      WAIT_B1:        leave = req_s;
      ACK_B0, ACK_B1: leave = !req_s;
      default:        leave = 1'b0;
    endcase
    tmo_hit = (state != WAIT_B0) && !leave && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Watchdog counter: counts cycles spent mid-message in one state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     tmo_cnt <= '0;
    else if (leave || tmo_hit || state == WAIT_B0) tmo_cnt <= '0;
    else                                          tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

  // Handshake FSM, beat capture and registered output pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= WAIT_B0;
      armed               <= 1'b0;
      discard             <= 1'b0;
      type_q              <= '0;
      num_q               <= '0;
      Ack_out             <= 1'b0;
      interboard_en       <= 1'b0;
      interboard_rst      <= 1'b0;
      interboard_msg_type <= '0;
      interboard_number   <= '0;
      frame_err           <= 1'b0;
    end else begin
      interboard_en  <= 1'b0;
      interboard_rst <= 1'b0;
      frame_err      <= 1'b0;

      if (!armed && primed && !req_s) armed <= 1'b1;

      case (state)
        WAIT_B0: begin
          if (armed && req_s) begin
            Ack_out <= 1'b1;
            state   <= ACK_B0;
            if (inter_data_in[TAG_BIT]) begin
              frame_err <= 1'b1;
              discard   <= 1'b1;
            end else begin
              type_q  <= inter_data_in[2:0];
              discard <= 1'b0;
            end
          end
        end
        ACK_B0: begin
          if (!req_s) begin
            Ack_out <= 1'b0;
            discard <= 1'b0;
            state   <= discard ? WAIT_B0 : WAIT_B1;
          end
        end
        WAIT_B1: begin
          if (req_s) begin
            Ack_out <= 1'b1;
            if (inter_data_in[TAG_BIT]) begin
              num_q <= inter_data_in[4:0];
              state <= ACK_B1;
            end else begin
              frame_err <= 1'b1;
              type_q    <= inter_data_in[2:0];
              state     <= ACK_B0;
            end
          end
        end
        ACK_B1: begin
          if (!req_s) begin
            Ack_out             <= 1'b0;
            interboard_en       <= 1'b1;
            interboard_rst      <= (type_q == MSG_RESET);
            interboard_msg_type <= type_q;
            interboard_number   <= num_q;
            state               <= WAIT_B0;
          end
        end
        default: state <= WAIT_B0;
      endcase

`ifdef INTER_RX_TIMEOUT_EN
      // Watchdog overrides the (idle) FSM step of this cycle
      if (tmo_hit) begin
        frame_err <= 1'b1;
        Ack_out   <= 1'b0;
        armed     <= 1'b0;
        discard   <= 1'b0;
        state     <= WAIT_B0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_inter_link_rx.sv
// Bench for inter_link_rx: directed sender handshakes, scoreboard of expected
// messages popped by an independent output monitor.
module tb_inter_link_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Request_in = 1'b0;
  logic [5:0] inter_data_in = '0;
  logic       Ack_out;
  logic       interboard_en;
  logic [2:0] interboard_msg_type;
  logic [4:0] interboard_number;
  logic       interboard_rst;
  logic       frame_err;

  typedef struct packed {
    logic [2:0] t;
    logic [4:0] n;
    logic       r;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ferr_seen = 0;

  always #5 clk = ~clk;

  inter_link_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) dut (
    .clk                 (clk),
    .rst                 (rst_n),
    .Request_in          (Request_in),
    .inter_data_in       (inter_data_in),
    .Ack_out             (Ack_out),
    .interboard_en       (interboard_en),
    .interboard_msg_type (interboard_msg_type),
    .interboard_number   (interboard_number),
    .interboard_rst      (interboard_rst),
    .frame_err           (frame_err)
  );

  // Monitor: pops the scoreboard whenever a message is presented
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (frame_err) ferr_seen++;
      if (interboard_en && frame_err) begin
        checks++; errors++;
        $display("FAIL en_ferr_overlap: both asserted at %0t", $time);
      end
      if (interboard_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_en: type=%0d num=%0d rst=%0b, none expected",
                   interboard_msg_type, interboard_number, interboard_rst);
        end else begin
          e = exp_q.pop_front();
          if (interboard_msg_type !== e.t || interboard_number !== e.n || interboard_rst !== e.r) begin
            errors++;
            $display("FAIL msg: got type=%0d num=%0d rst=%0b, want type=%0d num=%0d rst=%0b",
                     interboard_msg_type, interboard_number, interboard_rst, e.t, e.n, e.r);
          end
        end
      end else if (interboard_rst) begin
        checks++; errors++;
        $display("FAIL rst_without_en: interboard_rst=1 while interboard_en=0");
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic wait_ack(input logic level, output int n);
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (Ack_out == level) begin
        n = i;
        break;
      end
    end
  endtask

  // One four-phase beat; both edges must follow Request_in by 3 cycles
  task automatic send_beat(input logic [5:0] d);
    int n;
    @(negedge clk);
    inter_data_in = d;
    Request_in    = 1'b1;
    wait_ack(1'b1, n);
    check("ack_rise_latency", n, 3);
    @(negedge clk);
    Request_in = 1'b0;
    wait_ack(1'b0, n);
    check("ack_fall_latency", n, 3);
  endtask

  task automatic send_msg(input logic [5:0] b0, input logic [5:0] b1,
                          input logic [2:0] t, input logic [4:0] num, input logic r);
    exp_q.push_back('{t: t, n: num, r: r});
    send_beat(b0);
    send_beat(b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ack"},   int'(Ack_out), 0);
    check({tag, "_en"},    int'(interboard_en), 0);
    check({tag, "_type"},  int'(interboard_msg_type), 0);
    check({tag, "_num"},   int'(interboard_number), 0);
    check({tag, "_irst"},  int'(interboard_rst), 0);
    check({tag, "_ferr"},  int'(frame_err), 0);
  endtask

  initial begin
    int n;
    int seen_ack;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Type 2, number 23
    send_msg(6'h02, 6'h37, 3'd2, 5'd23, 1'b0);
    repeat (4) @(negedge clk);
    check("hold_type", int'(interboard_msg_type), 2);
    check("hold_num",  int'(interboard_number), 23);

    // Reset message: en and rst together, number 0
    send_msg(6'h00, 6'h20, 3'd0, 5'd0, 1'b1);
    repeat (3) @(negedge clk);

    // Stray beat 1 while idle: acked and dropped, then a valid message
    send_beat(6'h25);
    repeat (3) @(negedge clk);
    check("ferr_after_stray", ferr_seen, 1);
    check("hold_after_stray_type", int'(interboard_msg_type), 0);
    send_msg(6'h01, 6'h25, 3'd1, 5'd5, 1'b0);
    repeat (3) @(negedge clk);

    // Beat 0 where beat 1 was due restarts the message with the new type
    send_msg(6'h02, 6'h03, 3'd3, 5'd10, 1'b0);
    send_beat(6'h2A);
    repeat (3) @(negedge clk);
    check("ferr_after_retag", ferr_seen, 2);

    // Request held high through reset release is never acked
    @(negedge clk);
    rst_n = 1'b0;
    inter_data_in = 6'h02;
    Request_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_ack = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (Ack_out) seen_ack = 1;
    end
    check("no_ack_when_high_at_reset", seen_ack, 0);
    @(negedge clk);
    Request_in = 1'b0;
    repeat (6) @(negedge clk);
    send_msg(6'h03, 6'h21, 3'd3, 5'd1, 1'b0);
    repeat (3) @(negedge clk);

    // Reset mid-message: Ack drops at once and the partial message vanishes
    @(negedge clk);
    inter_data_in = 6'h04;
    Request_in = 1'b1;
    wait_ack(1'b1, n);
    check("mid_ack_rise", n, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_reset_ack_drop", int'(Ack_out), 0);
    Request_in = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("mid_reset");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Stall after beat 0 (reserved bits 4:3 set)
`ifdef INTER_RX_TIMEOUT_EN
    send_beat(6'h1A);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (frame_err) begin
        n = i;
        break;
      end
    end
    check("timeout_cycles", n, 100);
    check("timeout_ack", int'(Ack_out), 0);
    repeat (6) @(negedge clk);
    check("ferr_after_timeout", ferr_seen, 3);
    send_msg(6'h04, 6'h2C, 3'd4, 5'd12, 1'b0);
`else
    exp_q.push_back('{t: 3'd2, n: 5'd31, r: 1'b0});
    send_beat(6'h1A);
    repeat (150) @(negedge clk);
    check("no_timeout_ferr", ferr_seen, 2);
    send_beat(6'h3F);
`endif
    repeat (5) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, errors=%0d", errors + 1);
    $fatal(1);
  end

endmodule
